// File: rtl/user_evt_pkg.sv
// Shared constants, FSM state type and round-robin search helper for the user event servicer.
package user_evt_pkg;

  localparam int unsigned N_SRC_DEF = 12;
  localparam int unsigned IDX_W_DEF = 4;
  localparam int unsigned MAX_SRC   = 16;
  localparam int unsigned MAX_IDX_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // First set bit of pending at or above ptr, wrapping n_src-1 -> 0; 0 if none set.
  function automatic logic [MAX_IDX_W-1:0] rr_pick(
    input logic [MAX_SRC-1:0]   pending,
    input logic [MAX_IDX_W-1:0] ptr,
    input int unsigned          n_src
  );
    logic [MAX_IDX_W-1:0] sel;
    logic                 found;
    int unsigned          idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < MAX_SRC; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= n_src) idx = idx - n_src;
      if (!found && (off < n_src) && pending[idx[MAX_IDX_W-1:0]]) begin
        sel   = idx[MAX_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/user_evt_rr_pick.sv
// Combinational round-robin selector: picks the next pending source starting at ptr.
module user_evt_rr_pick
  import user_evt_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic [N_SRC-1:0] pending_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] sel_c_o,
  output logic             any_c_o
);

  logic [MAX_SRC-1:0]   pending_ext;
  logic [MAX_IDX_W-1:0] ptr_ext;

  // Widen to the helper's fixed width and run the search.
  always_comb begin
    pending_ext = MAX_SRC'(pending_i);
    ptr_ext     = MAX_IDX_W'(ptr_i);
    sel_c_o     = IDX_W'(rr_pick(pending_ext, ptr_ext, N_SRC));
    any_c_o     = |pending_i;
  end

endmodule

// File: rtl/user_evt_servicer.sv
// User event servicer: rising-edge capture into pending bits, round-robin
// presentation on a valid/ready port, aggregate pending flag and overflow pulse.
// Optional input synchroniser enabled by defining USER_EVT_SYNC_EN.
module user_evt_servicer
  import user_evt_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] user_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_idx,
  output logic             user_out,
  output logic             evt_ovf
);

  logic [N_SRC-1:0] s_in;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] acc_mask;
  logic             accept;
  logic             ovf_q, ovf_d;
  logic             uo_q;
  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] sel;
  logic             any;

`ifdef USER_EVT_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;

  // Two-flop synchroniser per line ahead of edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= user_in;
      sync2_q <= sync1_q;
    end
  end

  assign s_in = sync2_q;
`else
  assign s_in = user_in;
`endif

  // Round-robin search over the registered pending vector.
  user_evt_rr_pick #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .pending_i (pend_q),
    .ptr_i     (rr_q),
    .sel_c_o   (sel),
    .any_c_o   (any)
  );

  // Edge detect and pending update; a new edge wins over a same-cycle clear.
  always_comb begin
    accept = valid_q & evt_ready;
    rise   = s_in & ~prev_q;
    for (int i = 0; i < int'(N_SRC); i++) begin
      acc_mask[i] = accept && (idx_q == IDX_W'(i));
    end
    pend_d = rise | (pend_q & ~acc_mask);
    ovf_d  = |(rise & pend_q & ~acc_mask);
  end

  // Next-state and presentation logic; IDLE always costs one cycle between grants.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          idx_d   = sel;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (accept) begin
          valid_d = 1'b0;
          rr_d    = (idx_q == IDX_W'(N_SRC - 1)) ? '0 : idx_q + IDX_W'(1);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, pending and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      rr_q    <= '0;
      uo_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= s_in;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      uo_q    <= |pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_idx   = idx_q;
  assign user_out  = uo_q;
  assign evt_ovf   = ovf_q;

endmodule
